// File: rtl/elevator_call_dispatcher.sv
// SCAN call dispatcher: latches cabin and hall calls and steers the elevator
// core toward the next floor to serve in the current sweep direction.
module elevator_call_dispatcher #(
  parameter int unsigned BUTTONS_WIDTH = 8,
  parameter int unsigned LEVEL_WIDTH   = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [BUTTONS_WIDTH-1:0] btn_in,
  input  logic [BUTTONS_WIDTH-1:0] btn_up_out,
  input  logic [BUTTONS_WIDTH-1:0] btn_down_out,
  input  logic [LEVEL_WIDTH-1:0]   current_level,
  input  logic                     at_floor,
  input  logic                     serve_done,
  input  logic                     overload,
  output logic [BUTTONS_WIDTH-1:0] pend_in,
  output logic [BUTTONS_WIDTH-1:0] pend_up,
  output logic [BUTTONS_WIDTH-1:0] pend_down,
  output logic [LEVEL_WIDTH-1:0]   target_level,
  output logic                     move_up,
  output logic                     move_down,
  output logic                     stop_req,
  output logic                     direction
);
  localparam int unsigned BW = BUTTONS_WIDTH;
  localparam int unsigned LW = LEVEL_WIDTH;
  localparam logic [LW-1:0] TOP        = LW'(BW - 1);
  localparam logic [BW-1:0] UP_VALID   = {1'b0, {(BW-1){1'b1}}};
  localparam logic [BW-1:0] DOWN_VALID = {{(BW-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {IDLE, UP, DOWN, SERVE} state_t;

  state_t        state, state_nxt;
  logic [LW-1:0] lvl, target_nxt, up_target, down_target;
  logic [BW-1:0] above_m, below_m, at_m, any_raw;
  logic [BW-1:0] clr_in, clr_up, clr_down;
  logic [BW-1:0] eff_in, eff_up, eff_down, any_eff, up_cand, down_cand;
  logic          req_above, req_below, req_here, accept, ahead, dir_nxt;
  logic          up_found, down_found;

  assign lvl = (32'(current_level) >= BW) ? TOP : current_level;

  // Floor masks relative to the cabin position
  always_comb begin
    above_m = '0;
    below_m = '0;
    at_m    = '0;
    for (int f = 0; f < int'(BW); f++) begin
      above_m[f] = LW'(f) > lvl;
      below_m[f] = LW'(f) < lvl;
      at_m[f]    = LW'(f) == lvl;
    end
  end

  assign any_raw   = pend_in | pend_up | pend_down;
  assign req_above = |(any_raw & above_m);
  assign req_below = |(any_raw & below_m);

  // Calls retired by an accepted stop; the opposite hall call goes too when the sweep ends here
  always_comb begin
    clr_in   = '0;
    clr_up   = '0;
    clr_down = '0;
    accept   = (state == SERVE) && serve_done && !overload;
    if (accept) begin
      clr_in = at_m;
      if (lvl == TOP || lvl == '0) begin
        clr_up   = at_m;
        clr_down = at_m;
      end else if (direction) begin
        clr_up = at_m;
        if (!req_above) clr_down = at_m;
      end else begin
        clr_down = at_m;
        if (!req_below) clr_up = at_m;
      end
    end
  end

  assign eff_in   = pend_in & ~clr_in;
  assign eff_up   = pend_up & ~clr_up;
  assign eff_down = pend_down & ~clr_down;
  assign any_eff  = eff_in | eff_up | eff_down;
  assign req_here = |(any_eff & at_m);

  // Nearest call ahead in each sweep, else the far end of all outstanding calls
  always_comb begin
    up_cand     = (eff_in | eff_up) & (above_m | (at_floor ? at_m : '0));
    down_cand   = (eff_in | eff_down) & (below_m | (at_floor ? at_m : '0));
    up_target   = lvl;
    down_target = lvl;
    up_found    = 1'b0;
    down_found  = 1'b0;
    for (int f = int'(BW) - 1; f >= 0; f--) begin
      if (up_cand[f]) begin
        up_target = LW'(f);
        up_found  = 1'b1;
      end
    end
    for (int f = 0; f < int'(BW); f++) begin
      if (down_cand[f]) begin
        down_target = LW'(f);
        down_found  = 1'b1;
      end
    end
    if (!up_found) begin
      for (int f = 0; f < int'(BW); f++) begin
        if (any_eff[f]) up_target = LW'(f);
      end
    end
    if (!down_found) begin
      for (int f = int'(BW) - 1; f >= 0; f--) begin
        if (any_eff[f]) down_target = LW'(f);
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    dir_nxt    = direction;
    target_nxt = target_level;
    ahead      = direction ? req_above : req_below;
    case (state)
      IDLE: begin
        target_nxt = lvl;
        if (req_here && at_floor) begin
          state_nxt = SERVE;
        end else if (req_above && req_below) begin
          state_nxt  = direction ? UP : DOWN;
          target_nxt = direction ? up_target : down_target;
        end else if (req_above) begin
          state_nxt  = UP;
          dir_nxt    = 1'b1;
          target_nxt = up_target;
        end else if (req_below) begin
          state_nxt  = DOWN;
          dir_nxt    = 1'b0;
          target_nxt = down_target;
        end
      end
      UP: begin
        target_nxt = up_target;
        if (at_floor && up_target == lvl) begin
          state_nxt  = SERVE;
          target_nxt = lvl;
        end else if (!req_above) begin
          state_nxt  = IDLE;
          target_nxt = lvl;
        end
      end
      DOWN: begin
        target_nxt = down_target;
        if (at_floor && down_target == lvl) begin
          state_nxt  = SERVE;
          target_nxt = lvl;
        end else if (!req_below) begin
          state_nxt  = IDLE;
          target_nxt = lvl;
        end
      end
      SERVE: begin
        target_nxt = lvl;
        if (accept) begin
          if (ahead) begin
            state_nxt  = direction ? UP : DOWN;
            target_nxt = direction ? up_target : down_target;
          end else begin
            dir_nxt = ~direction;
            if (direction ? req_below : req_above) begin
              state_nxt  = direction ? DOWN : UP;
              target_nxt = direction ? down_target : up_target;
            end else begin
              state_nxt = IDLE;
            end
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      pend_in      <= '0;
      pend_up      <= '0;
      pend_down    <= '0;
      target_level <= '0;
      move_up      <= 1'b0;
      move_down    <= 1'b0;
      stop_req     <= 1'b0;
      direction    <= 1'b1;
    end else begin
      state        <= state_nxt;
      pend_in      <= eff_in | btn_in;
      pend_up      <= eff_up | (btn_up_out & UP_VALID);
      pend_down    <= eff_down | (btn_down_out & DOWN_VALID);
      target_level <= target_nxt;
      move_up      <= (state_nxt == UP);
      move_down    <= (state_nxt == DOWN);
      stop_req     <= (state_nxt == SERVE);
      direction    <= dir_nxt;
    end
  end
endmodule

// File: tb/tb_elevator_call_dispatcher.sv
// Bench for elevator_call_dispatcher: directed scenarios plus a randomized
// run against a floor-list scheduling model.
module tb_elevator_call_dispatcher;
  localparam int S_IDLE = 0, S_UP = 1, S_DOWN = 2, S_SERVE = 3;

  logic       clk, reset;
  logic [7:0] btn_in, btn_up_out, btn_down_out;
  logic [2:0] current_level;
  logic       at_floor, serve_done, overload;
  logic [7:0] pend_in, pend_up, pend_down;
  logic [2:0] target_level;
  logic       move_up, move_down, stop_req, direction;

  int checks = 0;
  int failures = 0;

  bit [7:0] m_in, m_up, m_down;
  int       m_st, m_tgt;
  bit       m_dir;

  elevator_call_dispatcher #(.BUTTONS_WIDTH(8), .LEVEL_WIDTH(3)) dut (
    .clk(clk), .reset(reset), .btn_in(btn_in), .btn_up_out(btn_up_out),
    .btn_down_out(btn_down_out), .current_level(current_level), .at_floor(at_floor),
    .serve_done(serve_done), .overload(overload), .pend_in(pend_in), .pend_up(pend_up),
    .pend_down(pend_down), .target_level(target_level), .move_up(move_up),
    .move_down(move_down), .stop_req(stop_req), .direction(direction)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int up_pick(bit [7:0] i, bit [7:0] u, bit [7:0] d, int lv, bit af);
    for (int f = lv; f < 8; f++) if ((i[f] | u[f]) && (f > lv || af)) return f;
    for (int f = 7; f >= 0; f--) if (i[f] | u[f] | d[f]) return f;
    return lv;
  endfunction

  function automatic int down_pick(bit [7:0] i, bit [7:0] u, bit [7:0] d, int lv, bit af);
    for (int f = lv; f >= 0; f--) if ((i[f] | d[f]) && (f < lv || af)) return f;
    for (int f = 0; f < 8; f++) if (i[f] | u[f] | d[f]) return f;
    return lv;
  endfunction

  // One clock of the collective-control rules, using the inputs currently driven
  task automatic model_step();
    int lv, ut, dt;
    bit acc, above, below, here;
    bit [7:0] ni, nu, nd;
    lv = (int'(current_level) > 7) ? 7 : int'(current_level);
    above = 0;
    below = 0;
    for (int f = 0; f < 8; f++) begin
      if (m_in[f] | m_up[f] | m_down[f]) begin
        if (f > lv) above = 1;
        if (f < lv) below = 1;
      end
    end
    acc = (m_st == S_SERVE) && serve_done && !overload;
    ni = m_in; nu = m_up; nd = m_down;
    if (acc) begin
      ni[lv] = 0;
      if (lv == 0 || lv == 7) begin nu[lv] = 0; nd[lv] = 0; end
      else if (m_dir) begin nu[lv] = 0; if (!above) nd[lv] = 0; end
      else begin nd[lv] = 0; if (!below) nu[lv] = 0; end
    end
    ut = up_pick(ni, nu, nd, lv, at_floor);
    dt = down_pick(ni, nu, nd, lv, at_floor);
    here = ni[lv] | nu[lv] | nd[lv];
    case (m_st)
      S_IDLE: begin
        m_tgt = lv;
        if (here && at_floor) m_st = S_SERVE;
        else if (above && (m_dir || !below)) begin m_st = S_UP; m_dir = 1; m_tgt = ut; end
        else if (below) begin m_st = S_DOWN; m_dir = 0; m_tgt = dt; end
      end
      S_UP: begin
        m_tgt = ut;
        if (at_floor && ut == lv) begin m_st = S_SERVE; m_tgt = lv; end
        else if (!above) begin m_st = S_IDLE; m_tgt = lv; end
      end
      S_DOWN: begin
        m_tgt = dt;
        if (at_floor && dt == lv) begin m_st = S_SERVE; m_tgt = lv; end
        else if (!below) begin m_st = S_IDLE; m_tgt = lv; end
      end
      default: begin
        m_tgt = lv;
        if (acc) begin
          if (!(m_dir ? above : below)) m_dir = !m_dir;
          if (m_dir ? above : below) begin
            m_st = m_dir ? S_UP : S_DOWN;
            m_tgt = m_dir ? ut : dt;
          end else m_st = S_IDLE;
        end
      end
    endcase
    m_in   = ni | btn_in;
    m_up   = nu | (btn_up_out & 8'h7F);
    m_down = nd | (btn_down_out & 8'hFE);
  endtask

  task automatic model_reset();
    m_in = 0; m_up = 0; m_down = 0; m_st = S_IDLE; m_tgt = 0; m_dir = 1;
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic release_buttons();
    btn_in = 0; btn_up_out = 0; btn_down_out = 0;
  endtask

  task automatic test_reset();
    reset = 1; release_buttons(); serve_done = 0; overload = 0;
    current_level = 0; at_floor = 1;
    model_reset();
    @(negedge clk); @(negedge clk);
    checks++;
    if ({pend_in, pend_up, pend_down} !== 24'h0) begin
      failures++; $display("FAIL reset_pend got=%h exp=%h", {pend_in, pend_up, pend_down}, 24'h0);
    end
    checks++;
    if ({target_level, move_up, move_down, stop_req, direction} !== 7'b000_0001) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=%b", {target_level, move_up, move_down, stop_req, direction}, 7'b000_0001);
    end
    reset = 0;
  endtask

  task automatic test_cabin_call();
    btn_in = 8'h80; cyc(); release_buttons();
    checks++;
    if (pend_in !== 8'h80 || move_up !== 1'b0) begin
      failures++; $display("FAIL t1_latch got pend_in=%h move_up=%b exp pend_in=80 move_up=0", pend_in, move_up);
    end
    cyc();
    checks++;
    if (move_up !== 1'b1 || target_level !== 3'd7) begin
      failures++; $display("FAIL t1_depart got move_up=%b tgt=%0d exp 1/7", move_up, target_level);
    end
    current_level = 7; cyc();
    checks++;
    if (stop_req !== 1'b1 || move_up !== 1'b0) begin
      failures++; $display("FAIL t1_stop got stop=%b up=%b exp 1/0", stop_req, move_up);
    end
    serve_done = 1; cyc(); serve_done = 0;
    checks++;
    if (pend_in !== 8'h00 || stop_req !== 1'b0 || direction !== 1'b0) begin
      failures++;
      $display("FAIL t1_served got pend_in=%h stop=%b dir=%b exp 00/0/0", pend_in, stop_req, direction);
    end
  endtask

  task automatic test_top_hall_call();
    btn_down_out = 8'h80; cyc(); release_buttons();
    cyc();
    checks++;
    if ({move_up, move_down, stop_req} !== 3'b001 || pend_down !== 8'h80) begin
      failures++;
      $display("FAIL t2_serve got umd=%b pend_down=%h exp 001/80", {move_up, move_down, stop_req}, pend_down);
    end
    serve_done = 1; cyc(); serve_done = 0;
    checks++;
    if (pend_down !== 8'h00 || stop_req !== 1'b0) begin
      failures++; $display("FAIL t2_clear got pend_down=%h stop=%b exp 00/0", pend_down, stop_req);
    end
  endtask

  task automatic test_edge_bits();
    btn_up_out = 8'h80; btn_down_out = 8'h01; cyc(); release_buttons(); cyc();
    checks++;
    if ({pend_up, pend_down} !== 16'h0 || {move_up, move_down, stop_req} !== 3'b000) begin
      failures++;
      $display("FAIL edge_bits got up=%h down=%h umd=%b exp 0/0/000", pend_up, pend_down, {move_up, move_down, stop_req});
    end
  endtask

  task automatic test_sweep_pickup();
    current_level = 0; cyc();
    btn_in = 8'h80; cyc(); release_buttons(); cyc();
    current_level = 1; cyc();
    current_level = 2; btn_up_out = 8'h10; cyc(); release_buttons(); cyc();
    checks++;
    if (target_level !== 3'd4 || move_up !== 1'b1) begin
      failures++; $display("FAIL t3_retarget got tgt=%0d up=%b exp 4/1", target_level, move_up);
    end
    current_level = 3; cyc();
    current_level = 4; cyc();
    checks++;
    if (stop_req !== 1'b1) begin
      failures++; $display("FAIL t3_stop4 got stop=%b exp 1", stop_req);
    end
    serve_done = 1; cyc(); serve_done = 0;
    checks++;
    if (move_up !== 1'b1 || target_level !== 3'd7 || pend_up !== 8'h00) begin
      failures++;
      $display("FAIL t3_resume got up=%b tgt=%0d pend_up=%h exp 1/7/00", move_up, target_level, pend_up);
    end
    current_level = 7; cyc();
    serve_done = 1; cyc(); serve_done = 0;
  endtask

  task automatic test_reverse();
    current_level = 5; cyc();
    btn_in = 8'h80; cyc(); release_buttons(); cyc();
    btn_down_out = 8'h08; cyc(); release_buttons();
    checks++;
    if (move_up !== 1'b1 || target_level !== 3'd7 || direction !== 1'b1) begin
      failures++; $display("FAIL t4_up got up=%b tgt=%0d dir=%b exp 1/7/1", move_up, target_level, direction);
    end
    current_level = 6; cyc();
    current_level = 7; cyc();
    serve_done = 1; cyc(); serve_done = 0;
    checks++;
    if (direction !== 1'b0 || target_level !== 3'd3 || move_down !== 1'b1 || pend_in !== 8'h00) begin
      failures++;
      $display("FAIL t4_reverse got dir=%b tgt=%0d down=%b pend_in=%h exp 0/3/1/00", direction, target_level, move_down, pend_in);
    end
    current_level = 3; cyc();
    checks++;
    if (stop_req !== 1'b1) begin
      failures++; $display("FAIL t4_stop3 got stop=%b exp 1", stop_req);
    end
    serve_done = 1; cyc(); serve_done = 0;
    checks++;
    if (pend_down !== 8'h00 || direction !== 1'b1 || stop_req !== 1'b0) begin
      failures++; $display("FAIL t4_done got pend_down=%h dir=%b stop=%b exp 00/1/0", pend_down, direction, stop_req);
    end
  endtask

  task automatic test_overload();
    btn_in = 8'h08; cyc(); release_buttons(); cyc();
    overload = 1; serve_done = 1; cyc(); serve_done = 0;
    checks++;
    if (stop_req !== 1'b1 || pend_in !== 8'h08) begin
      failures++; $display("FAIL t5_blocked got stop=%b pend_in=%h exp 1/08", stop_req, pend_in);
    end
    cyc();
    overload = 0; serve_done = 1; cyc(); serve_done = 0;
    checks++;
    if (stop_req !== 1'b0 || pend_in !== 8'h00) begin
      failures++; $display("FAIL t5_accepted got stop=%b pend_in=%h exp 0/00", stop_req, pend_in);
    end
  endtask

  task automatic test_reset_mid_and_set_wins();
    btn_in = 8'h01; btn_up_out = 8'h02; btn_down_out = 8'h04; cyc(); release_buttons(); cyc();
    checks++;
    if (move_down !== 1'b1 || target_level !== 3'd2) begin
      failures++; $display("FAIL t6_down got down=%b tgt=%0d exp 1/2", move_down, target_level);
    end
    #2 reset = 1;
    #1;
    model_reset();
    checks++;
    if ({pend_in, pend_up, pend_down, target_level, move_up, move_down, stop_req, direction} !== 31'h1) begin
      failures++;
      $display("FAIL t6_async_reset got=%h exp=%h",
               {pend_in, pend_up, pend_down, target_level, move_up, move_down, stop_req, direction}, 31'h1);
    end
    @(negedge clk); reset = 0;
    current_level = 2;
    btn_in = 8'h04; cyc(); release_buttons(); cyc();
    serve_done = 1; btn_in = 8'h04; cyc(); serve_done = 0; release_buttons();
    checks++;
    if (pend_in !== 8'h04) begin
      failures++; $display("FAIL t6_set_wins got pend_in=%h exp 04", pend_in);
    end
    cyc();
    serve_done = 1; cyc(); serve_done = 0;
    checks++;
    if (pend_in !== 8'h00) begin
      failures++; $display("FAIL t6_reserve got pend_in=%h exp 00", pend_in);
    end
  endtask

  task automatic test_random();
    logic [30:0] got, exp;
    int sw;
    bit [7:0] one;
    reset = 1; release_buttons(); serve_done = 0; overload = 0;
    current_level = 0; at_floor = 1; model_reset();
    @(negedge clk); reset = 0;
    sw = 0;
    for (int c = 0; c < 600; c++) begin
      release_buttons();
      if ($urandom_range(3) == 0) begin
        one = 8'b1 << $urandom_range(7);
        case ($urandom_range(2))
          0: btn_in = one;
          1: btn_up_out = one;
          default: btn_down_out = one;
        endcase
      end
      at_floor = ($urandom_range(7) != 0);
      overload = ($urandom_range(5) == 0);
      serve_done = 0;
      if (stop_req) begin
        sw++;
        if (sw >= 2) begin serve_done = 1; sw = 0; end
      end else sw = 0;
      if (move_up && current_level < target_level) current_level = current_level + 3'd1;
      if (move_down && current_level > target_level) current_level = current_level - 3'd1;
      cyc();
      got = {pend_in, pend_up, pend_down, target_level, move_up, move_down, stop_req, direction};
      exp = {m_in, m_up, m_down, 3'(m_tgt), m_st == S_UP, m_st == S_DOWN, m_st == S_SERVE, m_dir};
      checks++;
      if (got !== exp) begin
        failures++; $display("FAIL random_cycle%0d got=%h exp=%h", c, got, exp);
      end
    end
    release_buttons(); serve_done = 0; overload = 0;
  endtask

  initial begin
    test_reset();
    test_cabin_call();
    test_top_hall_call();
    test_edge_bits();
    test_sweep_pickup();
    test_reverse();
    test_overload();
    test_reset_mid_and_set_wins();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
